// File: rtl/mcs4_clockgen_if.sv
// Control and clock-output bundle for mcs4_clockgen.
// The generator uses the slave view; whoever drives run/step uses master.
interface mcs4_clockgen_if;
  logic       run;
  logic       step;
  logic       clk1;
  logic       clk2;
  logic       sync;
  logic       poc;
  logic [2:0] phase;
  logic       cycle_start;
  logic       halted;

  modport master (
    output run,
    output step,
    input  clk1,
    input  clk2,
    input  sync,
    input  poc,
    input  phase,
    input  cycle_start,
    input  halted
  );

  modport slave (
    input  run,
    input  step,
    output clk1,
    output clk2,
    output sync,
    output poc,
    output phase,
    output cycle_start,
    output halted
  );
endinterface

// File: rtl/mcs4_clockgen.sv
// MCS-4 two-phase clock, sync and power-on-clear generator.
// Define MCS4_SINGLE_STEP_EN to build in halt / single-step control.
module mcs4_clockgen #(
  parameter int CLK_DIV    = 4,
  parameter int POC_CYCLES = 16
) (
  input  logic             sysclk,
  input  logic             reset_n,
  mcs4_clockgen_if.slave   bus
);

  localparam logic [7:0] DIV_LAST   = 8'(CLK_DIV - 1);
  localparam logic [7:0] POC_TARGET = 8'(POC_CYCLES);

  logic [7:0] div_cnt;
  logic [7:0] div_n;
  logic [1:0] slot_cnt;
  logic [1:0] slot_n;
  logic [2:0] phase_cnt;
  logic [2:0] phase_n;
  logic [7:0] poc_cnt;
  logic [7:0] poc_cnt_n;
  logic       live;
  logic       live_n;

  logic       clk1_q;
  logic       clk2_q;
  logic       sync_q;
  logic       poc_q;
  logic       cycle_start_q;
  logic       halted_q;

  logic       cycle_end;
  logic       launch;
  logic       park;
  logic       halted_n;

  // live is low only while nothing is being clocked out: right after reset and in HALT
  assign cycle_end = live && (div_cnt == DIV_LAST) && (slot_cnt == 2'd3) &&
                     (phase_cnt == 3'd7);

`ifdef MCS4_SINGLE_STEP_EN
  typedef enum logic [1:0] {
    RUN  = 2'd0,
    HALT = 2'd1,
    STEP = 2'd2
  } state_t;

  state_t state;
  state_t state_n;
  logic   step_q;
  logic   step_rise;

  assign step_rise = bus.step & ~step_q;

  always_ff @(posedge sysclk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= RUN;
      step_q <= 1'b0;
    end else begin
      state  <= state_n;
      step_q <= bus.step;
    end
  end

  // Halt decisions are only taken at the X3 boundary so a cycle is never cut short
  always_comb begin
    state_n = state;
    launch  = 1'b0;
    park    = 1'b0;
    case (state)
      RUN: begin
        launch = !live;
        if (cycle_end && !bus.run && !poc_q) begin
          state_n = HALT;
          park    = 1'b1;
        end
      end
      HALT: begin
        if (bus.run) begin
          state_n = RUN;
          launch  = 1'b1;
        end else if (step_rise) begin
          state_n = STEP;
          launch  = 1'b1;
        end
      end
      STEP: begin
        if (cycle_end) begin
          if (bus.run) begin
            state_n = RUN;
          end else begin
            state_n = HALT;
            park    = 1'b1;
          end
        end
      end
      default: begin
        state_n = RUN;
      end
    endcase
  end

  assign halted_n = (state_n == HALT);
`else
  logic unused_controls;

  assign unused_controls = bus.run ^ bus.step;
  assign launch          = !live;
  assign park            = 1'b0;
  assign halted_n        = 1'b0;
`endif

  always_comb begin
    div_n     = div_cnt;
    slot_n    = slot_cnt;
    phase_n   = phase_cnt;
    live_n    = live;
    poc_cnt_n = poc_cnt;
    if (cycle_end && (poc_cnt != POC_TARGET)) begin
      poc_cnt_n = poc_cnt + 8'd1;
    end
    if (launch || park) begin
      live_n  = launch;
      div_n   = 8'd0;
      slot_n  = 2'd0;
      phase_n = 3'd0;
    end else if (live) begin
      if (div_cnt != DIV_LAST) begin
        div_n = div_cnt + 8'd1;
      end else begin
        div_n  = 8'd0;
        slot_n = slot_cnt + 2'd1;
        if (slot_cnt == 2'd3) begin
          phase_n = phase_cnt + 3'd1;
        end
      end
    end
  end

  always_ff @(posedge sysclk or negedge reset_n) begin
    if (!reset_n) begin
      div_cnt   <= 8'd0;
      slot_cnt  <= 2'd0;
      phase_cnt <= 3'd0;
      poc_cnt   <= 8'd0;
      live      <= 1'b0;
    end else begin
      div_cnt   <= div_n;
      slot_cnt  <= slot_n;
      phase_cnt <= phase_n;
      poc_cnt   <= poc_cnt_n;
      live      <= live_n;
    end
  end

  // Outputs are decoded from the next position so every pin comes straight off a flop
  always_ff @(posedge sysclk or negedge reset_n) begin
    if (!reset_n) begin
      clk1_q        <= 1'b0;
      clk2_q        <= 1'b0;
      sync_q        <= 1'b0;
      poc_q         <= 1'b1;
      cycle_start_q <= 1'b0;
      halted_q      <= 1'b0;
    end else begin
      clk1_q        <= live_n && (slot_n == 2'd0);
      clk2_q        <= live_n && (slot_n == 2'd2);
      sync_q        <= live_n && (phase_n == 3'd7);
      poc_q         <= (poc_cnt_n != POC_TARGET);
      cycle_start_q <= live_n && (slot_n == 2'd0) && (div_n == 8'd0) &&
                       (phase_n == 3'd0);
      halted_q      <= halted_n;
    end
  end

  assign bus.clk1        = clk1_q;
  assign bus.clk2        = clk2_q;
  assign bus.sync        = sync_q;
  assign bus.poc         = poc_q;
  assign bus.phase       = phase_cnt;
  assign bus.cycle_start = cycle_start_q;
  assign bus.halted      = halted_q;

endmodule
